// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD CMD-line engine serialising commands with CRC7 and capturing 48/136-bit responses
module sd_cmd_engine #(
  parameter int CLK_DIV_W    = 8,
  parameter int INIT_CLKS    = 80,
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CLKS     = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [5:0]           cmd_index,
  input  logic [31:0]          cmd_arg,
  input  logic [1:0]           resp_type,
  output logic                 resp_valid,
  output logic [5:0]           resp_index,
  output logic [127:0]         resp_data,
  output logic                 resp_timeout,
  output logic                 resp_crc_err,
  output logic                 sd_clk,
  output logic                 sd_cmd_o,
  output logic                 sd_cmd_oe,
  input  logic                 sd_cmd_i
);
  typedef enum logic [2:0] {INIT, IDLE, SEND, WAIT_RESP, RECV, TRAIL} state_t;
  state_t state, state_nx;
  logic [CLK_DIV_W-1:0] div_q, div_cnt;
  logic [31:0] cnt;
  logic [39:0] tx_sh;
  logic [127:0] rx_sh;
  logic [6:0] crc;
  logic [1:0] type_q;
  logic timeout_q, got_q;
  logic run, tick, rise, fall, inc, accept, is_long, done;

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    crc_step = {c[5:3], c[2] ^ b ^ c[6], c[1:0], b ^ c[6]};
  endfunction

  assign run     = state != IDLE;
  assign tick    = run && div_cnt == div_q;
  assign rise    = tick && !sd_clk;
  assign fall    = tick && sd_clk;
  assign inc     = state == SEND ? fall : rise;
  assign accept  = cmd_valid && cmd_ready;
  assign is_long = type_q == 2'b11;
  assign done    = state == TRAIL && state_nx == IDLE;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= INIT;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:      if (fall && cnt == INIT_CLKS) state_nx = IDLE;
      IDLE:      if (cmd_valid) state_nx = SEND;
      SEND:      if (fall && cnt == 32'd48) state_nx = type_q == 2'b00 ? TRAIL : WAIT_RESP;
      WAIT_RESP: if (rise) state_nx = !sd_cmd_i ? RECV : cnt == RESP_TIMEOUT - 1 ? TRAIL : WAIT_RESP;
      RECV:      if (rise && cnt == (is_long ? 32'd135 : 32'd47)) state_nx = TRAIL;
      TRAIL:     if (fall && cnt == NCC_CLKS) state_nx = IDLE;
      default:   state_nx = INIT;
    endcase
  end

  always_comb begin
    cmd_ready = state == IDLE;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_q        <= clk_div;
      div_cnt      <= '0;
      cnt          <= '0;
      sd_clk       <= 1'b0;
      sd_cmd_o     <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      crc          <= '0;
      type_q       <= '0;
      timeout_q    <= 1'b0;
      got_q        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_index   <= '0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
      resp_crc_err <= 1'b0;
    end else begin
      div_cnt <= (!run || tick) ? '0 : div_cnt + 1'b1;
      if (tick) sd_clk <= ~sd_clk;
      cnt <= state != state_nx ? (state_nx == RECV ? 32'd1 : 32'd0) : cnt + {31'b0, inc};
      if (state == INIT) sd_cmd_oe <= state_nx == INIT;
      else if (fall) sd_cmd_oe <= state_nx == SEND || state_nx == TRAIL;
      if (fall) sd_cmd_o <= state == SEND && cnt < 32'd47 ? (cnt < 32'd40 ? tx_sh[39] : crc[6]) : 1'b1;
      if (accept) begin
        div_q        <= clk_div;
        type_q       <= resp_type;
        tx_sh        <= {2'b01, cmd_index, cmd_arg};
        crc          <= '0;
        timeout_q    <= 1'b0;
        got_q        <= 1'b0;
        resp_timeout <= 1'b0;
        resp_crc_err <= 1'b0;
      end else if (state == SEND && fall) begin
        if (cnt < 32'd40) begin
          tx_sh <= tx_sh << 1;
          crc   <= crc_step(crc, tx_sh[39]);
        end else crc <= crc << 1;
      end else if (state == WAIT_RESP && rise) begin
        if (!sd_cmd_i) begin
          rx_sh <= '0;
          crc   <= '0;
          got_q <= 1'b1;
        end else if (state_nx == TRAIL) timeout_q <= 1'b1;
      end else if (state == RECV && rise) begin
        rx_sh <= {rx_sh[126:0], sd_cmd_i};
        if (is_long ? (cnt >= 32'd8 && cnt <= 32'd127) : cnt <= 32'd39) crc <= crc_step(crc, sd_cmd_i);
      end
      resp_valid <= done;
      if (done) begin
        resp_timeout <= timeout_q;
        resp_crc_err <= got_q && type_q[0] && crc != rx_sh[7:1];
        if (got_q) begin
          resp_index <= is_long ? 6'd0 : rx_sh[45:40];
          resp_data  <= is_long ? rx_sh : {96'b0, rx_sh[39:8]};
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed checks of the SD CMD engine against a small SD card model
module tb_sd_cmd_engine;
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic [7:0] clk_div = 8'd0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [5:0] cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [1:0] resp_type = 2'd0;
  logic resp_valid;
  logic [5:0] resp_index;
  logic [127:0] resp_data;
  logic resp_timeout, resp_crc_err;
  logic sd_clk, sd_cmd_o, sd_cmd_oe;
  logic sd_cmd_i = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [47:0] sent;
  int lat, wait_rises, trail_rises, card_bit;
  logic got_valid, valid_after, ready_after, to_after, crc_after;
  logic card_abort = 1'b0;
  logic [135:0] r2;

  sd_cmd_engine dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .clk_div(clk_div),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .resp_type(resp_type), .resp_valid(resp_valid), .resp_index(resp_index), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .resp_crc_err(resp_crc_err), .sd_clk(sd_clk),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_i(sd_cmd_i)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int k = 127; k >= 8; k--) begin
      fb = v[k] ^ c[6];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic init_phase(input string tag);
    int rises, bad, vals, n;
    logic prev;
    rises = 0; bad = 0; vals = 0; n = 0; prev = 1'b0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk_clk);
      n++;
      if (sd_clk && !prev) begin
        rises++;
        if (!(sd_cmd_oe && sd_cmd_o)) bad++;
      end
      if (resp_valid) vals++;
      prev = sd_clk;
    end
    chk({tag, "_ready"}, 136'(cmd_ready), 1);
    chk({tag, "_rises"}, 136'(rises), 80);
    chk({tag, "_oe_o_high"}, 136'(bad), 0);
    chk({tag, "_no_valid"}, 136'(vals), 0);
    repeat (4) @(negedge clk_clk);
    chk({tag, "_sdclk_stopped_low"}, 136'({sd_clk, cmd_ready}), 136'b01);
  endtask

  task automatic capture();
    int k;
    k = 0;
    sent = '0;
    while (k < 48) begin
      @(posedge sd_clk);
      #1;
      if (sd_cmd_oe) begin
        sent = {sent[46:0], sd_cmd_o};
        k++;
      end
    end
  endtask

  task automatic card(input logic [135:0] rf, input int rlen);
    @(negedge sd_cmd_oe);
    #1;
    repeat (2) @(negedge sd_clk);
    for (int k = rlen - 1; k >= 0 && !card_abort; k--) begin
      sd_cmd_i = rf[k];
      card_bit = rlen - 1 - k;
      @(negedge sd_clk);
    end
    sd_cmd_i = 1'b1;
  endtask

  task automatic watch();
    logic prev, seen, rel, rise;
    prev = sd_clk; seen = 1'b0; rel = 1'b0;
    got_valid = 1'b0; wait_rises = 0; trail_rises = 0; lat = 0;
    for (int n = 1; n <= 20000 && !got_valid; n++) begin
      @(negedge clk_clk);
      rise = sd_clk && !prev;
      if (seen && !sd_cmd_oe) rel = 1'b1;
      if (rise && rel && !sd_cmd_oe) wait_rises++;
      if (rise && rel && sd_cmd_oe) trail_rises++;
      if (sd_cmd_oe) seen = 1'b1;
      if (resp_valid) begin
        got_valid = 1'b1;
        lat = n;
      end
      prev = sd_clk;
    end
    @(negedge clk_clk);
    valid_after = resp_valid;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ, input logic [7:0] div);
    @(negedge clk_clk);
    clk_div = div; cmd_index = idx; cmd_arg = arg; resp_type = typ; cmd_valid = 1'b1;
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    ready_after = cmd_ready; to_after = resp_timeout; crc_after = resp_crc_err;
  endtask

  task automatic xact(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                      input logic [7:0] div, input logic reply, input logic [135:0] rf, input int rlen);
    issue(idx, arg, typ, div);
    fork
      capture();
      if (reply) card(rf, rlen);
      watch();
    join
  endtask

  initial begin
    r2 = {8'h3F, 120'h035344534431364780DEADBEEF0145, 8'h01};
    r2[7:1] = crc7(r2);
    repeat (3) @(negedge clk_clk);
    chk("rst_ctl", 136'({sd_clk, sd_cmd_o, sd_cmd_oe, cmd_ready, resp_valid, resp_timeout, resp_crc_err}), 136'b0100000);
    chk("rst_result", 136'({resp_index, resp_data}), 0);
    reset_reset = 1'b0;
    init_phase("init");

    xact(6'd0, 32'd0, 2'b00, 8'd0, 1'b0, '0, 0);
    chk("cmd0_ready_drop", 136'(ready_after), 0);
    chk("cmd0_frame", 136'(sent), 136'h400000000095);
    chk("cmd0_valid", 136'(got_valid), 1);
    chk("cmd0_latency", 136'(lat), 114);
    chk("cmd0_one_pulse", 136'(valid_after), 0);
    chk("cmd0_flags", 136'({resp_timeout, resp_crc_err}), 0);

    xact(6'd8, 32'h1AA, 2'b01, 8'd1, 1'b1, 136'h08000001AA13, 48);
    chk("cmd8_frame", 136'(sent), 136'h48000001AA87);
    chk("cmd8_valid", 136'(got_valid), 1);
    chk("cmd8_index", 136'(resp_index), 8);
    chk("cmd8_data", 136'(resp_data), 136'h1AA);
    chk("cmd8_flags", 136'({resp_timeout, resp_crc_err}), 0);

    xact(6'd8, 32'h1AA, 2'b01, 8'd0, 1'b1, 136'h08000001AA15, 48);
    chk("crcbad_valid", 136'(got_valid), 1);
    chk("crcbad_flags", 136'({resp_timeout, resp_crc_err}), 136'b01);

    xact(6'd8, 32'h1AA, 2'b10, 8'd0, 1'b1, 136'h08000001AA15, 48);
    chk("r3_crc_cleared_on_accept", 136'(crc_after), 0);
    chk("r3_valid", 136'(got_valid), 1);
    chk("r3_flags", 136'({resp_timeout, resp_crc_err}), 0);
    chk("r3_data", 136'({resp_index, resp_data}), {8'h0, 6'd8, 96'h0, 32'h1AA});

    xact(6'd8, 32'h1AA, 2'b01, 8'd3, 1'b0, '0, 0);
    chk("to_frame", 136'(sent), 136'h48000001AA87);
    chk("to_valid", 136'(got_valid), 1);
    chk("to_flags", 136'({resp_timeout, resp_crc_err}), 136'b10);
    chk("to_wait_rises", 136'(wait_rises), 64);
    chk("to_trail_rises", 136'(trail_rises), 8);

    xact(6'd2, 32'd0, 2'b11, 8'd0, 1'b1, r2, 136);
    chk("r2_to_cleared_on_accept", 136'(to_after), 0);
    chk("r2_valid", 136'(got_valid), 1);
    chk("r2_data", 136'(resp_data), 136'(r2[127:0]));
    chk("r2_index", 136'(resp_index), 0);
    chk("r2_flags", 136'({resp_timeout, resp_crc_err}), 0);

    card_bit = 0;
    issue(6'd2, 32'd0, 2'b11, 8'd0);
    fork
      card(r2, 136);
    join_none
    for (int n = 0; n < 5000 && card_bit < 60; n++) @(negedge clk_clk);
    chk("abort_reached_bit60", 136'(card_bit >= 60), 1);
    card_abort = 1'b1;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    chk("abort_rst_ctl", 136'({sd_clk, sd_cmd_o, sd_cmd_oe, cmd_ready, resp_valid, resp_timeout, resp_crc_err}), 136'b0100000);
    chk("abort_rst_result", 136'({resp_index, resp_data}), 0);
    reset_reset = 1'b0;
    init_phase("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
